// File: rtl/led_blink_scheduler.sv
// ============================================================================
// led_blink_scheduler
// ----------------------------------------------------------------------------
// Purpose:
//    Command-driven LED blink sequencer. A command (on ticks, off ticks,
//    repeat count) is taken over a valid/ready handshake. The block then
//    plays the ON/OFF pattern on the LED and pulses done when the last
//    repetition ends. A repeat count of 0 loops until abort.
//
// Parameters:
//    CLK_HZ    input clock frequency
//    TICK_HZ   phase time base; TICK_DIV = CLK_HZ/TICK_HZ must be >= 2
//    TW        width of the on/off tick fields
//    CW        width of the repeat count
//
// Ports:
//    clk        in   system clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    cmd_valid  in   command offered
//    cmd_ready  out  command can be accepted (from state/slot and abort only)
//    cmd_on     in   ON phase length in ticks
//    cmd_off    in   OFF phase length in ticks
//    cmd_count  in   repetitions, 0 = repeat until abort
//    abort      in   stop the current pattern (ignored when idle)
//    led        out  LED drive, 1 = ON
//    busy       out  pattern in progress
//    done       out  one-cycle pulse on natural completion
//
// Build option:
//    LED_BLINK_SCHED_QUEUE_EN  adds a one-entry pending command slot, so a
//                              command can be accepted while busy and is
//                              launched on the completion edge.
// ============================================================================
module led_blink_scheduler #(
   parameter int CLK_HZ  = 12_000_000,
   parameter int TICK_HZ = 1000,
   parameter int TW      = 16,
   parameter int CW      = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [TW-1:0] cmd_on,
   input  logic [TW-1:0] cmd_off,
   input  logic [CW-1:0] cmd_count,
   input  logic          abort,
   output logic          led,
   output logic          busy,
   output logic          done
);

   localparam int            TICK_DIV   = CLK_HZ / TICK_HZ;
   localparam int            PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ON   = 2'd1;
   localparam logic [1:0] S_OFF  = 2'd2;

   logic [1:0]    r_state;
   logic [PW-1:0] r_presc;
   logic [TW-1:0] r_ticks;
   logic [TW-1:0] r_on;
   logic [TW-1:0] r_off;
   logic [CW-1:0] r_count;
   logic          r_done;

   logic          w_accept;
   logic          w_wrap;
   logic          w_phaseEnd;
   logic          w_complete;
   logic          w_start;
   logic [TW-1:0] w_sOn;
   logic [TW-1:0] w_sOff;
   logic [CW-1:0] w_sCount;

   assign busy = (r_state != S_IDLE);
   assign led  = (r_state == S_ON);
   assign done = r_done;

   assign w_accept   = cmd_valid && cmd_ready;
   assign w_wrap     = (r_presc == PRESC_LAST);
   // The tick counter holds the ticks still to run including the current
   // one, so the phase ends on the wrap that would take it from 1 to 0.
   assign w_phaseEnd = busy && w_wrap && (r_ticks == TW'(1));
   // Natural completion: the last phase of the last repetition ends.
   assign w_complete = w_phaseEnd && ((r_state == S_OFF) || (r_off == '0))
                       && (r_count == CW'(1));

`ifdef LED_BLINK_SCHED_QUEUE_EN
   logic          r_pendFull;
   logic [TW-1:0] r_pendOn;
   logic [TW-1:0] r_pendOff;
   logic [CW-1:0] r_pendCount;
   logic          w_store;

   assign cmd_ready = !r_pendFull && !abort;

   // Pick what starts on this edge: a fresh command when idle, or on the
   // completion edge the pending command (or a command offered right then
   // with an empty slot). Anything accepted mid-pattern goes to the slot.
   always_comb begin
      w_start  = 1'b0;
      w_store  = 1'b0;
      w_sOn    = cmd_on;
      w_sOff   = cmd_off;
      w_sCount = cmd_count;
      if (!busy) begin
         w_start = w_accept;
      end else if (w_complete && !abort) begin
         if (r_pendFull) begin
            w_start  = 1'b1;
            w_sOn    = r_pendOn;
            w_sOff   = r_pendOff;
            w_sCount = r_pendCount;
         end else begin
            w_start = w_accept;
         end
      end else begin
         w_store = w_accept;
      end
   end

   // Pending slot: filled by a mid-pattern accept, emptied when its command
   // launches or when an abort kills the running pattern.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pendFull  <= 1'b0;
         r_pendOn    <= '0;
         r_pendOff   <= '0;
         r_pendCount <= '0;
      end else if (busy && abort) begin
         r_pendFull <= 1'b0;
      end else if (w_store) begin
         r_pendFull  <= 1'b1;
         r_pendOn    <= cmd_on;
         r_pendOff   <= cmd_off;
         r_pendCount <= cmd_count;
      end else if (w_complete && r_pendFull) begin
         r_pendFull <= 1'b0;
      end
   end
`else
   // Without a slot, commands are only taken while idle.
   assign cmd_ready = (r_state == S_IDLE) && !abort;
   assign w_start   = w_accept;
   assign w_sOn     = cmd_on;
   assign w_sOff    = cmd_off;
   assign w_sCount  = cmd_count;
`endif

   // Main sequencer. The prescaler restarts at every launch and phase entry
   // so each phase lasts exactly ticks*TICK_DIV cycles, and it stays at 0
   // while idle. Abort wins over everything, including a completion edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_presc <= '0;
         r_ticks <= '0;
         r_on    <= '0;
         r_off   <= '0;
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (busy && abort) begin
            r_state <= S_IDLE;
            r_presc <= '0;
         end else if (w_start) begin
            r_on    <= w_sOn;
            r_off   <= w_sOff;
            r_count <= w_sCount;
            r_presc <= '0;
            // An empty pattern finishes at once; a launch on the completion
            // edge also carries the finishing command's done pulse.
            r_done  <= w_complete || ((w_sOn == '0) && (w_sOff == '0));
            if (w_sOn != '0) begin
               r_state <= S_ON;
               r_ticks <= w_sOn;
            end else if (w_sOff != '0) begin
               r_state <= S_OFF;
               r_ticks <= w_sOff;
            end else begin
               r_state <= S_IDLE;
            end
         end else if (busy) begin
            r_presc <= w_wrap ? '0 : r_presc + 1'b1;
            if (w_phaseEnd) begin
               if ((r_state == S_ON) && (r_off != '0)) begin
                  r_state <= S_OFF;
                  r_ticks <= r_off;
               end else if (r_count == CW'(1)) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end else begin
                  // A count of 0 means endless, so it is never decremented.
                  if (r_count != '0) begin
                     r_count <= r_count - 1'b1;
                  end
                  if (r_on != '0) begin
                     r_state <= S_ON;
                     r_ticks <= r_on;
                  end else begin
                     r_state <= S_OFF;
                     r_ticks <= r_off;
                  end
               end
            end else if (w_wrap) begin
               r_ticks <= r_ticks - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// ============================================================================
// tb_led_blink_scheduler
// ----------------------------------------------------------------------------
// Scoreboard bench for led_blink_scheduler with CLK_HZ=4, TICK_HZ=1, so one
// tick is four clocks. Whenever a command is launched, the reference model
// pushes the whole expected {led,busy,done} timeline for it into expQ, one
// entry per clock after the launch edge. A monitor pops one entry per clock
// on the falling edge and compares; an empty queue means idle is expected.
// ============================================================================
module tb_led_blink_scheduler;

   localparam int CLK_HZ  = 4;
   localparam int TICK_HZ = 1;
   localparam int TW      = 16;
   localparam int CW      = 8;
   localparam int DIV     = CLK_HZ / TICK_HZ;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [TW-1:0] cmd_on = '0;
   logic [TW-1:0] cmd_off = '0;
   logic [CW-1:0] cmd_count = '0;
   logic          abort = 1'b0;
   logic          led;
   logic          busy;
   logic          done;

   int         nTests = 0;
   int         nFail = 0;
   logic [2:0] expQ[$];
   logic       lastBusy = 1'b0;
   logic       monEn = 1'b0;

`ifdef LED_BLINK_SCHED_QUEUE_EN
   logic pendFull = 1'b0;
   int   pendOn, pendOff, pendCnt;
`endif

   led_blink_scheduler #(
      .CLK_HZ (CLK_HZ),
      .TICK_HZ(TICK_HZ),
      .TW     (TW),
      .CW     (CW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_on   (cmd_on),
      .cmd_off  (cmd_off),
      .cmd_count(cmd_count),
      .abort    (abort),
      .led      (led),
      .busy     (busy),
      .done     (done)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Safety net so a stuck run still ends with a report.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: count it, and report it if it does not match.
   task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference timeline for one command launched at some edge: entry j is the
   // expected {led,busy,done} after launch edge + j. Each repetition is
   // (on+off) ticks long with the LED lit for the first on ticks; after the
   // last one the block is idle with done high for one clock. A count of 0
   // is endless, so a long stretch without done is queued and an abort is
   // expected to cut it short. mergeDone marks a launch on a completion edge.
   function automatic void pushTrace(input int on, input int off, input int cnt, input bit mergeDone);
      int         period;
      int         reps;
      logic [2:0] s;
      if (on == 0 && off == 0) begin
         expQ.push_back(3'b001);
         return;
      end
      period = (on + off) * DIV;
      reps   = (cnt == 0) ? 12 : cnt;
      for (int j = 0; j < period * reps; j++) begin
         s    = 3'b010;
         s[2] = ((j % period) < on * DIV);
         if (j == 0 && mergeDone) s[0] = 1'b1;
         expQ.push_back(s);
      end
      if (cnt != 0) expQ.push_back(3'b001);
   endfunction

   // Monitor: every clock, compare the DUT with the next expected entry.
   always @(negedge clk) begin
      logic [2:0] e;
      if (monEn) begin
         e = (expQ.size() != 0) ? expQ.pop_front() : 3'b000;
         lastBusy = e[1];
         checkOutput("led/busy/done", {led, busy, done}, e);
      end
   end

   // Drive one clock of stimulus (called just after a falling edge), check
   // cmd_ready against the model, update the model for what happens on the
   // coming rising edge, and return just after the next falling edge.
   task automatic applyStimulus(input bit v, input int on, input int off, input int cnt,
                                input bit ab, output bit acc);
      bit expReady;
      bit completing;
      cmd_valid = v;
      cmd_on    = TW'(on);
      cmd_off   = TW'(off);
      cmd_count = CW'(cnt);
      abort     = ab;
      #1;
`ifdef LED_BLINK_SCHED_QUEUE_EN
      expReady = !pendFull && !ab;
`else
      expReady = !lastBusy && !ab;
`endif
      checkOutput("cmd_ready", {2'b00, cmd_ready}, {2'b00, expReady});
      acc        = v && expReady;
      completing = lastBusy && (expQ.size() == 1) && (expQ[0] == 3'b001);
      if (ab && lastBusy) begin
         expQ.delete();
`ifdef LED_BLINK_SCHED_QUEUE_EN
         pendFull = 1'b0;
`endif
      end else begin
`ifdef LED_BLINK_SCHED_QUEUE_EN
         if (pendFull && completing) begin
            expQ.delete();
            pushTrace(pendOn, pendOff, pendCnt, 1'b1);
            pendFull = 1'b0;
         end
         if (acc) begin
            if (!lastBusy) begin
               pushTrace(on, off, cnt, 1'b0);
            end else if (completing) begin
               expQ.delete();
               pushTrace(on, off, cnt, 1'b1);
            end else begin
               pendFull = 1'b1;
               pendOn   = on;
               pendOff  = off;
               pendCnt  = cnt;
            end
         end
`else
         if (acc) pushTrace(on, off, cnt, 1'b0);
`endif
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      cmd_valid = 1'b0;
      abort     = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      bit acc;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0, 1'b0, acc);
   endtask

   // Let the current pattern (and any pending one) drain, with a bound.
   task automatic waitIdle(input int limit);
      int n;
      n = 0;
      while ((lastBusy || expQ.size() != 0) && n < limit) begin
         idleCycles(1);
         n++;
      end
      checkOutput("drain to idle", {2'b00, lastBusy || (expQ.size() != 0)}, 3'b000);
      idleCycles(2);
   endtask

   // Asynchronous reset in the middle of a cycle: outputs must clear at once.
   task automatic applyReset();
      rst_n = 1'b0;
      #1;
      checkOutput("async reset outputs", {led, busy, done}, 3'b000);
      checkOutput("reset cmd_ready", {2'b00, cmd_ready}, 3'b001);
      expQ.delete();
      lastBusy = 1'b0;
`ifdef LED_BLINK_SCHED_QUEUE_EN
      pendFull = 1'b0;
`endif
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bit acc;
      int n, on, off, cnt;

      // Reset values.
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset outputs", {led, busy, done}, 3'b000);
      checkOutput("reset cmd_ready", {2'b00, cmd_ready}, 3'b001);
      rst_n = 1'b1;
      monEn = 1'b1;
      idleCycles(2);

      // on=2 off=1 count=3: 8 lit, 4 dark, three times, done 36 after accept.
      applyStimulus(1'b1, 2, 1, 3, 1'b0, acc);
      waitIdle(100);

      // Empty pattern: done next cycle, never busy.
      applyStimulus(1'b1, 0, 0, 5, 1'b0, acc);
      waitIdle(10);
      applyStimulus(1'b1, 0, 0, 0, 1'b0, acc);
      waitIdle(10);

      // Endless 1/1 blink for 10 periods, then abort.
      applyStimulus(1'b1, 1, 1, 0, 1'b0, acc);
      idleCycles(80);
      applyStimulus(1'b0, 0, 0, 0, 1'b1, acc);
      waitIdle(10);

      // Abort with a command offered while idle: nothing accepted.
      applyStimulus(1'b1, 2, 2, 1, 1'b1, acc);
      idleCycles(3);

      // OFF-only pattern.
      applyStimulus(1'b1, 0, 2, 2, 1'b0, acc);
      waitIdle(40);

      // Reset in the middle of an ON phase, then exact timing afterwards.
      applyStimulus(1'b1, 3, 1, 2, 1'b0, acc);
      idleCycles(5);
      applyReset();
      idleCycles(1);
      applyStimulus(1'b1, 1, 2, 2, 1'b0, acc);
      waitIdle(40);

`ifdef LED_BLINK_SCHED_QUEUE_EN
      // Queue: second command accepted while busy launches on the first's
      // done edge; a third stalls until the slot is free again.
      applyStimulus(1'b1, 2, 1, 1, 1'b0, acc);
      idleCycles(3);
      applyStimulus(1'b1, 1, 0, 1, 1'b0, acc);
      checkOutput("queued accept", {2'b00, acc}, 3'b001);
      n = 0;
      do begin
         applyStimulus(1'b1, 3, 0, 1, 1'b0, acc);
         n++;
      end while (!acc && n < 30);
      checkOutput("third command accepted", {2'b00, acc}, 3'b001);
      waitIdle(100);
`endif

      // Randomized commands, idle gaps and occasional aborts.
      for (int i = 0; i < 400; i++) begin
         on  = $urandom_range(0, 3);
         off = $urandom_range(0, 3);
         cnt = (on == 0 && off == 0) ? $urandom_range(0, 3) : $urandom_range(1, 3);
         applyStimulus(($urandom % 3) == 0, on, off, cnt, ($urandom % 40) == 0, acc);
      end
      waitIdle(200);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
